// File: rtl/decode_if.sv
// ID-stage bus: IF/ID latch and MEM/WB write-back in, ID/EX pipeline register out.
interface decode_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       if_id_instr;
  logic [31:0]       if_id_npc;
  logic              ex_mem_pc_src;
  logic              mem_wb_reg_write;
  logic [4:0]        mem_wb_write_reg;
  logic [DATA_W-1:0] wb_write_data;

  logic [1:0]        id_ex_wb;
  logic [2:0]        id_ex_m;
  logic [3:0]        id_ex_ex;
  logic [31:0]       id_ex_npc;
  logic [DATA_W-1:0] id_ex_readdat1;
  logic [DATA_W-1:0] id_ex_readdat2;
  logic [DATA_W-1:0] id_ex_sign_ext;
  logic [4:0]        id_ex_instr_2016;
  logic [4:0]        id_ex_instr_1511;

  modport master (
    output if_id_instr, if_id_npc, ex_mem_pc_src,
           mem_wb_reg_write, mem_wb_write_reg, wb_write_data,
    input  id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_readdat1,
           id_ex_readdat2, id_ex_sign_ext, id_ex_instr_2016, id_ex_instr_1511
  );

  modport slave (
    input  if_id_instr, if_id_npc, ex_mem_pc_src,
           mem_wb_reg_write, mem_wb_write_reg, wb_write_data,
    output id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_readdat1,
           id_ex_readdat2, id_ex_sign_ext, id_ex_instr_2016, id_ex_instr_1511
  );
endinterface

// File: rtl/decode.sv
// ID stage: register file, control decode, sign extend and ID/EX register; 1 clk latency, no backpressure.
// DECODE_RF_BYPASS_EN selects write-first RF reads (default read-first); flush zeroes control fields only.
module decode #(
  parameter int DATA_W   = 32,
  parameter int RF_DEPTH = 32
) (
  input logic     clk,
  input logic     rst,
  decode_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [DATA_W-1:0] rf [RF_DEPTH];

  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd;
  logic [1:0]        wb_ctl;
  logic [2:0]        m_ctl;
  logic [3:0]        ex_ctl;
  logic              wr_en;
  logic [DATA_W-1:0] rd1, rd2, sext;

  assign opcode = bus.if_id_instr[31:26];
  assign rs     = bus.if_id_instr[25:21];
  assign rt     = bus.if_id_instr[20:16];
  assign rd     = bus.if_id_instr[15:11];
  assign sext   = {{(DATA_W-16){bus.if_id_instr[15]}}, bus.if_id_instr[15:0]};
  assign wr_en  = bus.mem_wb_reg_write && (bus.mem_wb_write_reg != 5'd0);

  always_comb begin
    wb_ctl = 2'b00;
    m_ctl  = 3'b000;
    ex_ctl = 4'b0000;
    case (opcode)
      OP_RTYPE: begin wb_ctl = 2'b10; m_ctl = 3'b000; ex_ctl = 4'b1100; end
      OP_LW:    begin wb_ctl = 2'b11; m_ctl = 3'b010; ex_ctl = 4'b0001; end
      OP_SW:    begin wb_ctl = 2'b00; m_ctl = 3'b001; ex_ctl = 4'b0001; end
      OP_BEQ:   begin wb_ctl = 2'b00; m_ctl = 3'b100; ex_ctl = 4'b0010; end
      default:  ;
    endcase
  end

  // RF[0] is never written, so it reads as zero without a special case.
`ifdef DECODE_RF_BYPASS_EN
  assign rd1 = (wr_en && bus.mem_wb_write_reg == rs) ? bus.wb_write_data : rf[rs];
  assign rd2 = (wr_en && bus.mem_wb_write_reg == rt) ? bus.wb_write_data : rf[rt];
`else
  assign rd1 = rf[rs];
  assign rd2 = rf[rt];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.id_ex_wb         <= '0;
      bus.id_ex_m          <= '0;
      bus.id_ex_ex         <= '0;
      bus.id_ex_npc        <= '0;
      bus.id_ex_readdat1   <= '0;
      bus.id_ex_readdat2   <= '0;
      bus.id_ex_sign_ext   <= '0;
      bus.id_ex_instr_2016 <= '0;
      bus.id_ex_instr_1511 <= '0;
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else begin
      bus.id_ex_wb         <= bus.ex_mem_pc_src ? 2'b00   : wb_ctl;
      bus.id_ex_m          <= bus.ex_mem_pc_src ? 3'b000  : m_ctl;
      bus.id_ex_ex         <= bus.ex_mem_pc_src ? 4'b0000 : ex_ctl;
      bus.id_ex_npc        <= bus.if_id_npc;
      bus.id_ex_readdat1   <= rd1;
      bus.id_ex_readdat2   <= rd2;
      bus.id_ex_sign_ext   <= sext;
      bus.id_ex_instr_2016 <= rt;
      bus.id_ex_instr_1511 <= rd;
      // Write-back is independent of flush; only reset blocks it.
      if (wr_en) rf[bus.mem_wb_write_reg] <= bus.wb_write_data;
    end
  end
endmodule
